// File: rtl/regfile_mp_sb.sv
// Multi-port register file (NR read / NW write) with a per-register busy scoreboard.
// Latency: reads are combinational with same-cycle write bypass; writes and busy updates land at the clock edge.
// Backpressure: none; every port is accepted every cycle.
module regfile_mp_sb #(
  parameter int XLEN          = 32,
  parameter int REG_NUM       = 32,
  parameter int RF_ADDR_WIDTH = 5,
  parameter int NR            = 2,
  parameter int NW            = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NR*RF_ADDR_WIDTH-1:0] rf_raddr,
  output logic [NR*XLEN-1:0]          rf_rdata,
  output logic [NR-1:0]               rf_rbusy,
  input  logic [NW-1:0]               rf_wen,
  input  logic [NW*RF_ADDR_WIDTH-1:0] rf_waddr,
  input  logic [NW*XLEN-1:0]          rf_wdata,
  input  logic                        sb_set,
  input  logic [RF_ADDR_WIDTH-1:0]    sb_addr,
  input  logic                        sb_flush
);

  logic [XLEN-1:0]          r_regs [REG_NUM];
  logic [REG_NUM-1:0]       r_busy;
  logic [REG_NUM-1:0]       w_busy_nxt;

  logic [RF_ADDR_WIDTH-1:0] w_raddr [NR];
  logic [XLEN-1:0]          w_rdata [NR];
  logic                     w_rbusy [NR];
  logic [RF_ADDR_WIDTH-1:0] w_waddr [NW];
  logic [XLEN-1:0]          w_wdata [NW];

  // Unpack the flat port buses into per-port views.
  for (genvar k = 0; k < NR; k++) begin : g_rd
    assign w_raddr[k]                  = rf_raddr[k*RF_ADDR_WIDTH +: RF_ADDR_WIDTH];
    assign rf_rdata[k*XLEN +: XLEN]    = w_rdata[k];
    assign rf_rbusy[k]                 = w_rbusy[k];
  end
  for (genvar j = 0; j < NW; j++) begin : g_wr
    assign w_waddr[j] = rf_waddr[j*RF_ADDR_WIDTH +: RF_ADDR_WIDTH];
    assign w_wdata[j] = rf_wdata[j*XLEN +: XLEN];
  end

  // Read mux: stored value, overridden by matching writes (ascending loop so the
  // highest-index port wins), with x0 forced to zero last.
  always_comb begin
    for (int k = 0; k < NR; k++) begin
      w_rdata[k] = r_regs[w_raddr[k]];
      w_rbusy[k] = r_busy[w_raddr[k]];
      for (int j = 0; j < NW; j++) begin
        if (rf_wen[j] && (w_waddr[j] == w_raddr[k])) begin
          w_rdata[k] = w_wdata[j];
          w_rbusy[k] = 1'b0;
        end
      end
      if (w_raddr[k] == '0) begin
        w_rdata[k] = '0;
        w_rbusy[k] = 1'b0;
      end
    end
  end

  // Next busy vector: flush, then write-clears, then issue-set so a new producer wins.
  always_comb begin
    w_busy_nxt = r_busy;
    if (sb_flush) begin
      w_busy_nxt = '0;
    end
    for (int j = 0; j < NW; j++) begin
      if (rf_wen[j] && (w_waddr[j] != '0)) begin
        w_busy_nxt[w_waddr[j]] = 1'b0;
      end
    end
    if (sb_set && (sb_addr != '0)) begin
      w_busy_nxt[sb_addr] = 1'b1;
    end
  end

  // Register storage: reset clears all; otherwise later write ports override earlier ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      for (int j = 0; j < NW; j++) begin
        if (rf_wen[j] && (w_waddr[j] != '0)) begin
          r_regs[w_waddr[j]] <= w_wdata[j];
        end
      end
    end
  end

  // Busy scoreboard register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Bench for regfile_mp_sb: directed scenarios with literal expectations plus randomized traffic.
// A behavioural model (array of values + array of busy flags) is checked against the DUT every cycle.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_regfile_mp_sb;

  localparam int XL = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int NW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR*AW-1:0]  rf_raddr;
  logic [NR*XL-1:0]  rf_rdata;
  logic [NR-1:0]     rf_rbusy;
  logic [NW-1:0]     rf_wen;
  logic [NW*AW-1:0]  rf_waddr;
  logic [NW*XL-1:0]  rf_wdata;
  logic              sb_set;
  logic [AW-1:0]     sb_addr;
  logic              sb_flush;

  int n_chk = 0;
  int n_err = 0;
  logic chk_en = 1'b0;

  logic [XL-1:0] m_regs [32];
  logic          m_busy [32];

  regfile_mp_sb #(.XLEN(XL), .REG_NUM(32), .RF_ADDR_WIDTH(AW), .NR(NR), .NW(NW)) dut (
    .clk(clk), .rst(rst),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .rf_rbusy(rf_rbusy),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .sb_set(sb_set), .sb_addr(sb_addr), .sb_flush(sb_flush)
  );

  always #5 clk = ~clk;

  // Expected {busy, data} for read port k from the model and the current inputs.
  function automatic logic [XL:0] exp_rd(int k);
    logic [AW-1:0] a;
    a = rf_raddr[k*AW +: AW];
    if (a == 0) return '0;
    for (int j = NW - 1; j >= 0; j--) begin
      if (rf_wen[j] && rf_waddr[j*AW +: AW] == a) return {1'b0, rf_wdata[j*XL +: XL]};
    end
    return {m_busy[a], m_regs[a]};
  endfunction

  // Apply one clock edge worth of architectural effect to the model.
  task automatic model_update();
    logic [AW-1:0] a;
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        m_regs[i] = '0;
        m_busy[i] = 1'b0;
      end
      return;
    end
    for (int j = 0; j < NW; j++) begin
      a = rf_waddr[j*AW +: AW];
      if (rf_wen[j] && a != 0) m_regs[a] = rf_wdata[j*XL +: XL];
    end
    if (sb_flush) for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    for (int j = 0; j < NW; j++) begin
      a = rf_waddr[j*AW +: AW];
      if (rf_wen[j] && a != 0) m_busy[a] = 1'b0;
    end
    if (sb_set && sb_addr != 0) m_busy[sb_addr] = 1'b1;
  endtask

  // Per-cycle comparison of every read port against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < NR; k++) begin
        logic [XL:0] e;
        e = exp_rd(k);
        n_chk++;
        if (rf_rdata[k*XL +: XL] !== e[XL-1:0] || rf_rbusy[k] !== e[XL]) begin
          n_err++;
          $display("FAIL model_port%0d t=%0t: got data=%h busy=%b expected data=%h busy=%b",
                   k, $time, rf_rdata[k*XL +: XL], rf_rbusy[k], e[XL-1:0], e[XL]);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [XL-1:0] act, input logic [XL-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [XL-1:0] rd(int k);
    return rf_rdata[k*XL +: XL];
  endfunction

  task automatic idle();
    rst = 1'b0; rf_wen = '0; rf_waddr = '0; rf_wdata = '0;
    sb_set = 1'b0; sb_addr = '0; sb_flush = 1'b0;
  endtask

  task automatic wr(input int p, input logic [AW-1:0] a, input logic [XL-1:0] d);
    rf_wen[p] = 1'b1;
    rf_waddr[p*AW +: AW] = a;
    rf_wdata[p*XL +: XL] = d;
  endtask

  task automatic rdaddr(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rf_raddr[0 +: AW]  = a0;
    rf_raddr[AW +: AW] = a1;
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
    idle();
    rf_raddr = '0;
    // Writes and sb_set while reset is held must have no effect.
    rst = 1'b1;
    wr(0, 5'd3, 32'hCAFEF00D); wr(1, 5'd17, 32'h0BADBEEF);
    sb_set = 1'b1; sb_addr = 5'd3;
    step();
    wr(0, 5'd31, 32'h13572468); sb_addr = 5'd31;
    step();
    idle();
    chk_en = 1'b1;

    for (int a = 1; a < 32; a++) begin
      rdaddr(a[AW-1:0], 5'(32 - a));
      settle();
      chk("reset_data0", rd(0), 32'h0);
      chk("reset_data1", rd(1), 32'h0);
      chk("reset_busy", {30'd0, rf_rbusy}, 32'h0);
      step();
    end

    // x0 discard and basic write on port 0.
    wr(0, 5'd0, 32'hDEADBEEF); rdaddr(5'd0, 5'd0);
    settle();
    chk("x0_nobypass", rd(0), 32'h0);
    step();
    idle(); wr(0, 5'd5, 32'h12345678);
    step();
    idle(); rdaddr(5'd0, 5'd5);
    settle();
    chk("x0_read", rd(0), 32'h0);
    chk("x5_read", rd(1), 32'h12345678);
    step();

    // Same-cycle conflict: higher port wins in bypass and in storage.
    wr(0, 5'd7, 32'h11111111); wr(1, 5'd7, 32'h22222222); rdaddr(5'd7, 5'd7);
    settle();
    chk("conflict_bypass_p1", rd(1), 32'h22222222);
    chk("conflict_bypass_p0", rd(0), 32'h22222222);
    step();
    idle();
    settle();
    chk("conflict_stored", rd(1), 32'h22222222);
    step();

    // Scoreboard set is not visible in the same cycle, visible next cycle.
    sb_set = 1'b1; sb_addr = 5'd9; rdaddr(5'd9, 5'd9);
    settle();
    chk("set_same_cycle_busy", {31'd0, rf_rbusy[0]}, 32'h0);
    step();
    idle();
    settle();
    chk("set_busy", {31'd0, rf_rbusy[0]}, 32'h1);
    step();
    wr(0, 5'd9, 32'hA5A5A5A5);
    settle();
    chk("wclr_bypass_data", rd(0), 32'hA5A5A5A5);
    chk("wclr_bypass_busy", {31'd0, rf_rbusy[0]}, 32'h0);
    step();
    idle();
    settle();
    chk("wclr_after_busy", {31'd0, rf_rbusy[1]}, 32'h0);
    chk("wclr_after_data", rd(1), 32'hA5A5A5A5);
    step();
    sb_set = 1'b1; sb_addr = 5'd9; wr(1, 5'd9, 32'h5A5A5A5A);
    step();
    idle();
    settle();
    chk("set_beats_clear", {31'd0, rf_rbusy[0]}, 32'h1);
    chk("set_beats_clear_data", rd(0), 32'h5A5A5A5A);
    step();

    // sb_set to x0 is ignored.
    sb_set = 1'b1; sb_addr = 5'd0;
    step();
    idle(); rdaddr(5'd0, 5'd9);
    settle();
    chk("set_x0_busy", {31'd0, rf_rbusy[0]}, 32'h0);
    step();

    // Flush together with set leaves only the set register busy.
    sb_set = 1'b1; sb_addr = 5'd3; step();
    sb_addr = 5'd4; step();
    sb_addr = 5'd10; step();
    sb_addr = 5'd4; sb_flush = 1'b1; step();
    idle(); rdaddr(5'd3, 5'd4);
    settle();
    chk("flush_x3", {31'd0, rf_rbusy[0]}, 32'h0);
    chk("flush_x4", {31'd0, rf_rbusy[1]}, 32'h1);
    step();
    rdaddr(5'd10, 5'd9);
    settle();
    chk("flush_x10", {31'd0, rf_rbusy[0]}, 32'h0);
    chk("flush_x9", {31'd0, rf_rbusy[1]}, 32'h0);
    step();

    // Reset overrides a same-cycle write and set.
    wr(0, 5'd6, 32'hFFFF0000); sb_set = 1'b1; sb_addr = 5'd6;
    step();
    wr(0, 5'd6, 32'h0F0F0F0F); sb_set = 1'b1; sb_addr = 5'd6; rst = 1'b1;
    step();
    idle(); rdaddr(5'd6, 5'd5);
    settle();
    chk("rst_mid_data", rd(0), 32'h0);
    chk("rst_mid_busy", {31'd0, rf_rbusy[0]}, 32'h0);
    chk("rst_mid_x5", rd(1), 32'h0);
    step();

    // Randomized traffic on a narrow address window to provoke conflicts.
    for (int c = 0; c < 4000; c++) begin
      rst      = ($urandom_range(0, 99) == 0);
      sb_flush = ($urandom_range(0, 15) == 0);
      sb_set   = $urandom_range(0, 1) == 1;
      sb_addr  = 5'($urandom_range(0, 7));
      rf_wen   = 2'($urandom);
      for (int j = 0; j < NW; j++) begin
        rf_waddr[j*AW +: AW] = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
        rf_wdata[j*XL +: XL] = $urandom;
      end
      for (int k = 0; k < NR; k++) begin
        rf_raddr[k*AW +: AW] = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      end
      step();
    end

    idle();
    settle();
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
- Parametrised successor to the core register file: NR combinational read ports, NW write ports, and a per-register busy scoreboard for the issue stage.
- Sits in the decode/issue stage of the core.
  - Write ports are driven by writeback/commit.
  - The busy-set port is driven by issue.
  - Read ports feed operand fetch and the hazard check.
- x0 is hardwired to zero. Writes are bypassed to same-cycle reads.

Parameters:
XLEN  32  data width of each register
REG_NUM  32  number of architectural registers, power of two
RF_ADDR_WIDTH  5  address width; must equal log2(REG_NUM)
NR  2  number of read ports, 1..4
NW  2  number of write ports, 1..4

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
rf_raddr  in  NR*RF_ADDR_WIDTH  read addresses; port k uses slice [k*AW +: AW]
rf_rdata  out  NR*XLEN  read data; port k uses slice [k*XLEN +: XLEN]
rf_rbusy  out  NR  busy bit of the register addressed by read port k
rf_wen  in  NW  write enable per write port
rf_waddr  in  NW*RF_ADDR_WIDTH  write addresses
rf_wdata  in  NW*XLEN  write data
sb_set  in  1  mark register sb_addr busy (issue of a new producer)
sb_addr  in  RF_ADDR_WIDTH  destination register being issued
sb_flush  in  1  clear every busy bit (pipeline flush)

Behaviour:
- Storage: REG_NUM x XLEN registers plus a REG_NUM-bit busy vector. Both are updated only on the rising edge of clk.
- Reset (rst=1 at a clock edge):
  - All registers and all busy bits become 0.
  - Reset overrides every write, sb_set and sb_flush in that cycle.
  - Once reset has taken effect, every rf_rdata reads 0 and every rf_rbusy reads 0, unless a write is being bypassed.
- Write:
  - For each port j with rf_wen[j]=1 and rf_waddr_j != 0, rf_wdata_j is stored at the edge.
  - A write to x0 is discarded; it neither stores data nor clears a busy bit.
- Write conflict: if several enabled ports target the same address, the highest-index port wins. This applies to both stored data and bypass data.
- Read (combinational, zero latency), per port k, in priority order:
  1. rf_raddr_k == 0 -> data 0, busy 0.
  2. Any enabled write port matches rf_raddr_k -> data is that port's rf_wdata (highest index among matches), busy 0 (bypass).
  3. Otherwise -> stored data and stored busy bit.
- Scoreboard update at each edge, applied in this order:
  1. sb_flush=1 clears all busy bits.
  2. Each enabled write with nonzero address clears that register's busy bit.
  3. sb_set=1 with sb_addr != 0 sets that register's busy bit.
- Scoreboard boundary cases:
  - A set and a clear to the same register in the same cycle leave it busy (the new producer wins).
  - sb_flush together with sb_set leaves only sb_addr busy.
  - sb_set with sb_addr=0 is ignored.
- Busy-bit bypass applies only to the write-clear path. A same-cycle sb_set is not visible on rf_rbusy until the next cycle.
- No X propagation: with rf_wen=0, the values on rf_waddr and rf_wdata have no effect.
- Addresses are always in range because REG_NUM = 2^RF_ADDR_WIDTH.

Test Plan:
- Reset: apply arbitrary writes while rst=1, then deassert; read x1..x31 on both ports -> all data 0x00000000, all busy 0.
- x0 and basic write: write x0=0xDEADBEEF and x5=0x12345678 on port 0; next cycle read x0 and x5 -> 0x00000000 and 0x12345678.
- Bypass and conflict:
  - Same cycle: port0 writes x7=0x11111111, port1 writes x7=0x22222222, read port 1 addresses x7 -> rdata 0x22222222 that cycle.
  - Next cycle with rf_wen=0 -> stored value 0x22222222.
- Scoreboard set/clear:
  - sb_set x9, then read x9 -> busy 1.
  - Write x9=0xA5A5A5A5 -> same-cycle read shows data 0xA5A5A5A5, busy 0; busy stays 0 afterwards.
  - Simultaneous sb_set x9 and write x9 -> busy 1 next cycle.
- Flush: set busy on x3, x4 and x10; assert sb_flush with sb_set x4 -> next cycle only x4 is busy.
- Reset mid-operation: sb_set x6 and a write to x6 issued in the same cycle as rst=1 -> next cycle x6 reads data 0, busy 0.
